// File: rtl/ddr_row_scheduler.sv
// DDR-domain sequencer for the Game of Life row pipeline: optional row write-back, row read, periodic refresh.
// Define MIDBURST_REFRESH_EN to let a pending refresh split a burst at its midpoint.
module ddr_row_scheduler #(
    parameter int WORDS          = 40,
    parameter int DATA_W         = 16,
    parameter int ROW_W          = 9,
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lineStart,
    input  logic              writeEn,
    input  logic [ROW_W-1:0]  writeRowIdx,
    input  logic [ROW_W-1:0]  readRowIdx,
    output logic [5:0]        wrWordIdx,
    input  logic [DATA_W-1:0] wrWordData,
    output logic              rdValid,
    output logic [5:0]        rdWordIdx,
    output logic [DATA_W-1:0] rdData,
    output logic              read,
    output logic              write,
    output logic              refresh,
    output logic [23:0]       readAddress,
    output logic [23:0]       writeAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    input  logic              readAcknowledge,
    input  logic              writeAcknowledge,
    input  logic              refreshAcknowledge,
    output logic              busy,
    output logic              overrun
);
    localparam int               PAD_W    = 24 - ROW_W - 6;
    localparam int               CNT_W    = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [5:0]       LAST_W   = 6'(WORDS - 1);
`ifdef MIDBURST_REFRESH_EN
    localparam logic [5:0]       HALF_W   = 6'(WORDS / 2);
`endif

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_REFRESH} state_t;

    state_t             state_q, state_d, ret_q, ret_d;
    logic [5:0]         word_q, word_d;
    logic [ROW_W-1:0]   wrow_q, wrow_d, rrow_q, rrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d, ovr_q, ovr_d;
    logic               rd_valid_q, rd_valid_d;
    logic [5:0]         rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               expire, pend_now;

    // Requests decode straight from state so an asynchronous reset drops them at once.
    assign write        = (state_q == S_WRITE);
    assign read         = (state_q == S_READ);
    assign refresh      = (state_q == S_REFRESH);
    assign busy         = (state_q != S_IDLE);
    assign overrun      = ovr_q;
    assign wrWordIdx    = word_q;
    assign writeData    = wrWordData;
    assign writeAddress = {{PAD_W{1'b0}}, wrow_q, word_q};
    assign readAddress  = {{PAD_W{1'b0}}, rrow_q, word_q};
    assign rdValid      = rd_valid_q;
    assign rdWordIdx    = rd_idx_q;
    assign rdData       = rd_data_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        ret_d      = ret_q;
        word_d     = word_q;
        wrow_d     = wrow_q;
        rrow_d     = rrow_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;
        expire     = (cnt_q == CNT_LAST);
        pend_now   = pend_q | expire;
        cnt_d      = expire ? '0 : cnt_q + CNT_W'(1);
        pend_d     = expire | (pend_q & ~(refresh & refreshAcknowledge));
        ovr_d      = ovr_q | (lineStart & busy);

        case (state_q)
            S_IDLE: begin
                if (lineStart) begin
                    wrow_d = writeRowIdx;
                    rrow_d = readRowIdx;
                    word_d = '0;
                end
                // A line request that collides with a refresh is parked in ret_q, not lost.
                if (pend_now) begin
                    state_d = S_REFRESH;
                    ret_d   = lineStart ? (writeEn ? S_WRITE : S_READ) : S_IDLE;
                end else if (lineStart) begin
                    state_d = writeEn ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (writeAcknowledge) begin
                    if (word_q == LAST_W) begin
                        word_d  = '0;
                        state_d = pend_now ? S_REFRESH : S_READ;
                        ret_d   = S_READ;
                    end else begin
                        word_d = word_q + 6'd1;
`ifdef MIDBURST_REFRESH_EN
                        if (word_d == HALF_W && pend_now) begin
                            state_d = S_REFRESH;
                            ret_d   = S_WRITE;
                        end
`endif
                    end
                end
            end
            S_READ: begin
                if (readAcknowledge) begin
                    rd_valid_d = 1'b1;
                    rd_idx_d   = word_q;
                    rd_data_d  = readData;
                    if (word_q == LAST_W) begin
                        word_d  = '0;
                        state_d = pend_now ? S_REFRESH : S_IDLE;
                        ret_d   = S_IDLE;
                    end else begin
                        word_d = word_q + 6'd1;
`ifdef MIDBURST_REFRESH_EN
                        if (word_d == HALF_W && pend_now) begin
                            state_d = S_REFRESH;
                            ret_d   = S_READ;
                        end
`endif
                    end
                end
            end
            default: begin
                if (refreshAcknowledge) state_d = ret_q;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            word_q     <= '0;
            wrow_q     <= '0;
            rrow_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            word_q     <= word_d;
            wrow_q     <= wrow_d;
            rrow_q     <= rrow_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule
